// File: rtl/fu_mul_sequencer.sv
// Shift-and-add 32x32 -> 64 unsigned multiply sequencer that borrows the
// shared function unit for 32 fixed iterations per multiply.
module fu_mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [3:0]       fu_fs,
  output logic [4:0]       fu_sh,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  input  logic [WIDTH-1:0] fu_fout,
  input  logic             fu_carryout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0] FS_PASS_A = 4'b0000;
  localparam logic [3:0] FS_ADD    = 4'b0010;
  localparam logic [3:0] FS_ZERO   = 4'b1111;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [5:0]       r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= multiplicand;
            r_hi    <= '0;
            r_lo    <= multiplier;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          // {carry, sum, lo} shifted right one place: the carry lands in hi's MSB.
          r_hi  <= {fu_carryout, fu_fout[WIDTH-1:1]};
          r_lo  <= {fu_fout[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    fu_fs       = FS_ZERO;
    fu_sh       = '0;
    fu_a        = '0;
    fu_b        = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        fu_a  = r_hi;
        fu_b  = r_mcand;
        fu_fs = r_lo[0] ? FS_ADD : FS_PASS_A;
        if (r_cnt == 6'd31) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign product_hi = r_hi;
  assign product_lo = r_lo;

endmodule
